// File: rtl/queue_multi_pkg.sv
// Shared constants and types for the sixteen-channel FIFO bank.
package queue_multi_pkg;

    localparam int NUM_CH = 16;
    localparam int IDX_W  = 4;

    typedef logic [IDX_W-1:0] ch_idx_t;

endpackage : queue_multi_pkg

// File: rtl/queue_multi_ram.sv
// Simple dual-port RAM: one write port, one read port with a registered output.
// Contents are never cleared; the read register only loads when re is high.
module queue_multi_ram #(
    parameter  int DEPTH = 131072,
    parameter  int WIDTH = 28,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read port.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule : queue_multi_ram

// File: rtl/queue_multi.sv
// Sixteen independent FIFO channels sharing one statically partitioned RAM.
// Channel c owns addresses {c, pointer}. No handshake: callers test
// not_empty/full first; pushes to a full channel and pops from an empty one
// are discarded. Optional sticky error flags: define QUEUE_MULTI_ERR_EN.
module queue_multi
    import queue_multi_pkg::*;
#(
    parameter int DEPTH = 131072,
    parameter int WIDTH = 28
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  ch_idx_t           wr_idx,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  ch_idx_t           rd_idx,
    output logic [WIDTH-1:0]  rd_data,
    output logic              rd_valid,
    output logic [NUM_CH-1:0] not_empty,
    output logic [NUM_CH-1:0] full
`ifdef QUEUE_MULTI_ERR_EN
    ,
    output logic              err_ovf,
    output logic              err_unf
`endif
);

    localparam int CD = DEPTH / NUM_CH;
    localparam int PW = $clog2(CD);
    localparam int CW = PW + 1;
    localparam int AW = IDX_W + PW;

    logic [PW-1:0]     wptr_q [NUM_CH];
    logic [PW-1:0]     wptr_d [NUM_CH];
    logic [PW-1:0]     rptr_q [NUM_CH];
    logic [PW-1:0]     rptr_d [NUM_CH];
    logic [CW-1:0]     cnt_q  [NUM_CH];
    logic [CW-1:0]     cnt_d  [NUM_CH];
    logic [NUM_CH-1:0] not_empty_q, not_empty_d;
    logic [NUM_CH-1:0] full_q, full_d;
    logic              rd_valid_q, rd_valid_d;
    logic              push_ok, pop_ok;
    logic [WIDTH-1:0]  ram_rdata;

    // Accept decisions use the registered flags, i.e. the pre-cycle counts,
    // so a same-channel pop never frees room for a push in that cycle.
    always_comb begin
        push_ok = wr_en && !full_q[wr_idx];
        pop_ok  = rd_en && not_empty_q[rd_idx];
    end

    // Next-state of per-channel pointers, counts and status flags.
    always_comb begin
        rd_valid_d = pop_ok;
        for (int c = 0; c < NUM_CH; c++) begin
            wptr_d[c] = wptr_q[c];
            rptr_d[c] = rptr_q[c];
            cnt_d[c]  = cnt_q[c];
            if (push_ok && (wr_idx == IDX_W'(c))) begin
                wptr_d[c] = wptr_q[c] + PW'(1);
            end
            if (pop_ok && (rd_idx == IDX_W'(c))) begin
                rptr_d[c] = rptr_q[c] + PW'(1);
            end
            cnt_d[c] = cnt_q[c]
                     + CW'(push_ok && (wr_idx == IDX_W'(c)))
                     - CW'(pop_ok  && (rd_idx == IDX_W'(c)));
            not_empty_d[c] = (cnt_d[c] != '0);
            full_d[c]      = (cnt_d[c] == CW'(CD));
        end
    end

    // Register bank state; reset wins over any same-cycle transfer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                wptr_q[c] <= '0;
                rptr_q[c] <= '0;
                cnt_q[c]  <= '0;
            end
            not_empty_q <= '0;
            full_q      <= '0;
            rd_valid_q  <= 1'b0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                wptr_q[c] <= wptr_d[c];
                rptr_q[c] <= rptr_d[c];
                cnt_q[c]  <= cnt_d[c];
            end
            not_empty_q <= not_empty_d;
            full_q      <= full_d;
            rd_valid_q  <= rd_valid_d;
        end
    end

    queue_multi_ram #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (push_ok && rst_n),
        .waddr (AW'({wr_idx, wptr_q[wr_idx]})),
        .wdata (wr_data),
        .re    (pop_ok && rst_n),
        .raddr (AW'({rd_idx, rptr_q[rd_idx]})),
        .rdata (ram_rdata)
    );

    // The RAM read register is not reset, so mask it outside valid cycles.
    always_comb begin
        rd_data = rd_valid_q ? ram_rdata : '0;
    end

    assign rd_valid  = rd_valid_q;
    assign not_empty = not_empty_q;
    assign full      = full_q;

`ifdef QUEUE_MULTI_ERR_EN
    logic err_ovf_q, err_ovf_d;
    logic err_unf_q, err_unf_d;

    // Sticky flags for dropped pushes and rejected pops.
    always_comb begin
        err_ovf_d = err_ovf_q || (wr_en && full_q[wr_idx]);
        err_unf_d = err_unf_q || (rd_en && !not_empty_q[rd_idx]);
    end

    // Error flag registers, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_ovf_q <= 1'b0;
            err_unf_q <= 1'b0;
        end else begin
            err_ovf_q <= err_ovf_d;
            err_unf_q <= err_unf_d;
        end
    end

    assign err_ovf = err_ovf_q;
    assign err_unf = err_unf_q;
`endif

endmodule : queue_multi

// File: tb/tb_queue_multi.sv
// Bench for queue_multi (DEPTH=256, CD=16). Checks status and popped data
// against a per-channel reference queue model and a fixed vector table.
// Define QUEUE_MULTI_ERR_EN to also check the sticky error flags.
module tb_queue_multi;
    import queue_multi_pkg::*;

    localparam int DEPTH = 256;
    localparam int WIDTH = 28;
    localparam int CD    = DEPTH / NUM_CH;

    // ---------------- clock / reset / DUT ----------------
    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              wr_en = 1'b0;
    logic [3:0]        wr_idx = '0;
    logic [WIDTH-1:0]  wr_data = '0;
    logic              rd_en = 1'b0;
    logic [3:0]        rd_idx = '0;
    logic [WIDTH-1:0]  rd_data;
    logic              rd_valid;
    logic [NUM_CH-1:0] not_empty;
    logic [NUM_CH-1:0] full;
`ifdef QUEUE_MULTI_ERR_EN
    logic              err_ovf, err_unf;
    logic              m_ovf = 1'b0, m_unf = 1'b0;
`endif

    always #5 clk = ~clk;

    queue_multi #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_idx    (wr_idx),
        .wr_data   (wr_data),
        .rd_en     (rd_en),
        .rd_idx    (rd_idx),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .not_empty (not_empty),
        .full      (full)
`ifdef QUEUE_MULTI_ERR_EN
        ,
        .err_ovf   (err_ovf),
        .err_unf   (err_unf)
`endif
    );

    // ---------------- scoreboard state ----------------
    int               n_checks = 0;
    int               n_fail   = 0;
    logic [WIDTH-1:0] exp_q [$];
    logic [WIDTH-1:0] model_q [NUM_CH][$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [NUM_CH-1:0] model_ne();
        logic [NUM_CH-1:0] v;
        for (int c = 0; c < NUM_CH; c++) v[c] = (model_q[c].size() != 0);
        return v;
    endfunction

    function automatic logic [NUM_CH-1:0] model_full();
        logic [NUM_CH-1:0] v;
        for (int c = 0; c < NUM_CH; c++) v[c] = (model_q[c].size() == CD);
        return v;
    endfunction

    // ---------------- driver: one clock of push/pop ----------------
    task automatic cycle(input logic we, input logic [3:0] wi, input logic [WIDTH-1:0] wd,
                         input logic re, input logic [3:0] ri);
        logic push_ok, pop_ok;
        @(negedge clk);
        wr_en = we; wr_idx = wi; wr_data = wd;
        rd_en = re; rd_idx = ri;
        push_ok = we && (model_q[wi].size() < CD);
        pop_ok  = re && (model_q[ri].size() != 0);
        if (pop_ok)  exp_q.push_back(model_q[ri].pop_front());
        if (push_ok) model_q[wi].push_back(wd);
`ifdef QUEUE_MULTI_ERR_EN
        if (we && !push_ok) m_ovf = 1'b1;
        if (re && !pop_ok)  m_unf = 1'b1;
`endif
        @(posedge clk);
        #1;
        wr_en = 1'b0; rd_en = 1'b0;
        check("rd_valid", rd_valid, pop_ok);
        if (exp_q.size() != 0) begin
            if (rd_valid) check("rd_data", rd_data, exp_q.pop_front());
            else void'(exp_q.pop_front());
        end
        check("not_empty", not_empty, model_ne());
        check("full", full, model_full());
`ifdef QUEUE_MULTI_ERR_EN
        check("err_ovf", err_ovf, m_ovf);
        check("err_unf", err_unf, m_unf);
`endif
    endtask

    // Reset for one clock, optionally with a transfer in flight.
    task automatic do_reset(input logic we, input logic [3:0] wi, input logic re, input logic [3:0] ri);
        @(negedge clk);
        rst_n = 1'b0;
        wr_en = we; wr_idx = wi; wr_data = 28'h5A5A5A5;
        rd_en = re; rd_idx = ri;
        @(posedge clk);
        #1;
        wr_en = 1'b0; rd_en = 1'b0;
        for (int c = 0; c < NUM_CH; c++) model_q[c].delete();
        exp_q.delete();
        check("rst_not_empty", not_empty, 16'h0000);
        check("rst_full", full, 16'h0000);
        check("rst_rd_valid", rd_valid, 1'b0);
        check("rst_rd_data", rd_data, 28'h0);
`ifdef QUEUE_MULTI_ERR_EN
        m_ovf = 1'b0; m_unf = 1'b0;
        check("rst_err_ovf", err_ovf, 1'b0);
        check("rst_err_unf", err_unf, 1'b0);
`endif
        rst_n = 1'b1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic             we;
        logic [3:0]       wi;
        logic [WIDTH-1:0] wd;
        logic             re;
        logic [3:0]       ri;
        logic [15:0]      ne;
        logic [15:0]      fu;
        logic             vld;
        logic [WIDTH-1:0] rd;
    } vec_t;

    vec_t tbl [9];

    initial begin
        tbl[0] = '{1'b1, 4'd5,  28'h1234567, 1'b0, 4'd0, 16'h0020, 16'h0, 1'b0, 28'h0};
        tbl[1] = '{1'b0, 4'd0,  28'h0,       1'b1, 4'd5, 16'h0000, 16'h0, 1'b1, 28'h1234567};
        tbl[2] = '{1'b1, 4'd0,  28'hA,       1'b0, 4'd0, 16'h0001, 16'h0, 1'b0, 28'h0};
        tbl[3] = '{1'b1, 4'd0,  28'hB,       1'b0, 4'd0, 16'h0001, 16'h0, 1'b0, 28'h0};
        tbl[4] = '{1'b1, 4'd0,  28'hC,       1'b0, 4'd0, 16'h0001, 16'h0, 1'b0, 28'h0};
        tbl[5] = '{1'b1, 4'd15, 28'hF,       1'b0, 4'd0, 16'h8001, 16'h0, 1'b0, 28'h0};
        tbl[6] = '{1'b0, 4'd0,  28'h0,       1'b1, 4'd0, 16'h8001, 16'h0, 1'b1, 28'hA};
        tbl[7] = '{1'b0, 4'd0,  28'h0,       1'b1, 4'd0, 16'h8001, 16'h0, 1'b1, 28'hB};
        tbl[8] = '{1'b0, 4'd0,  28'h0,       1'b1, 4'd0, 16'h8000, 16'h0, 1'b1, 28'hC};

        do_reset(1'b0, 4'd0, 1'b0, 4'd0);

        // Basic push/pop and ordering.
        for (int i = 0; i < 9; i++) begin
            cycle(tbl[i].we, tbl[i].wi, tbl[i].wd, tbl[i].re, tbl[i].ri);
            check("tbl_not_empty", not_empty, tbl[i].ne);
            check("tbl_full", full, tbl[i].fu);
            check("tbl_rd_valid", rd_valid, tbl[i].vld);
            if (tbl[i].vld) check("tbl_rd_data", rd_data, tbl[i].rd);
        end

        // Fill channel 3, overflow, drain with pointer wrap.
        for (int i = 0; i < CD; i++) cycle(1'b1, 4'd3, WIDTH'($urandom_range(32'h0FFF_FFFF, 0)), 1'b0, 4'd0);
        check("fill_full", full, 16'h0008);
        cycle(1'b1, 4'd3, 28'hDEADBEE, 1'b0, 4'd0);
        check("ovf_full_kept", full, 16'h0008);
`ifdef QUEUE_MULTI_ERR_EN
        check("ovf_flag", err_ovf, 1'b1);
`endif
        for (int i = 0; i < CD; i++) cycle(1'b0, 4'd0, '0, 1'b1, 4'd3);
        check("drain_empty", not_empty[3], 1'b0);

        // Full channel, same-cycle push and pop: pop taken, push dropped.
        for (int i = 0; i < CD; i++) cycle(1'b1, 4'd3, WIDTH'(32'h100 + i), 1'b0, 4'd0);
        cycle(1'b1, 4'd3, 28'h0BADBAD, 1'b1, 4'd3);
        check("full_pp_data", rd_data, 28'h100);
        check("full_pp_notfull", full[3], 1'b0);
        for (int i = 0; i < CD - 1; i++) cycle(1'b0, 4'd0, '0, 1'b1, 4'd3);
        check("full_pp_drained", not_empty[3], 1'b0);

        // Empty channel 7: pop ignored; same-cycle push+pop keeps the push.
        cycle(1'b0, 4'd0, '0, 1'b1, 4'd7);
        check("unf_no_valid", rd_valid, 1'b0);
`ifdef QUEUE_MULTI_ERR_EN
        check("unf_flag", err_unf, 1'b1);
`endif
        cycle(1'b1, 4'd7, 28'h77, 1'b1, 4'd7);
        check("empty_pp_no_valid", rd_valid, 1'b0);
        check("empty_pp_ne7", not_empty[7], 1'b1);
        cycle(1'b0, 4'd0, '0, 1'b1, 4'd7);
        check("empty_pp_data", rd_data, 28'h77);
        check("empty_pp_ne7_clr", not_empty[7], 1'b0);

        // Different channels in the same cycle.
        cycle(1'b1, 4'd9, 28'h99, 1'b0, 4'd0);
        cycle(1'b1, 4'd2, 28'h22, 1'b1, 4'd9);
        check("diff_data", rd_data, 28'h99);
        check("diff_ne9", not_empty[9], 1'b0);
        check("diff_ne2", not_empty[2], 1'b1);

        // Random traffic on a few channels to hit full/empty often.
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(1, 0)), 4'($urandom_range(3, 0)),
                  WIDTH'($urandom_range(32'h0FFF_FFFF, 0)),
                  1'($urandom_range(1, 0)), 4'($urandom_range(3, 0)));
        end

        // Reset with channel 1 holding 4 words and a transfer in flight.
        do_reset(1'b0, 4'd0, 1'b0, 4'd0);
        for (int i = 0; i < 4; i++) cycle(1'b1, 4'd1, WIDTH'(32'h10 + i), 1'b0, 4'd0);
        check("pre_rst_ne1", not_empty, 16'h0002);
        do_reset(1'b1, 4'd1, 1'b1, 4'd1);
        cycle(1'b0, 4'd0, '0, 1'b1, 4'd1);
        check("post_rst_pop_ignored", rd_valid, 1'b0);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_queue_multi
